// File: rtl/lsu_axi_lite_master_pkg.sv
// Shared definitions for the load/store unit AXI4-Lite master.
//   - funct3 load/store encodings (size in [1:0], unsigned flag in [2])
//   - AXI response codes
//   - FSM state encoding
//   - latched request record and misalignment helper
package lsu_axi_lite_master_pkg;

  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Request fields captured when a transaction opens.
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  funct3;
  } req_t;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane steering for the LSU.
//   Store side: st_funct3/st_off/st_data -> st_strb (byte enables) and
//               st_wdata (store data replicated onto every lane it may hit).
//   Load side:  ld_word shifted down by the byte offset, then sign- or
//               zero-extended according to ld_funct3 -> ld_data.
module lsu_data_align
  import lsu_axi_lite_master_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_strb,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;

  // Replicating the data means the slave picks the right lane via wstrb alone.
  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = st_data;
    case (st_funct3[1:0])
      2'b00: begin
        st_strb  = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_strb  = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_strb  = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  assign ld_shift = ld_word >> {ld_off, 3'b000};

  always_comb begin
    ld_data = ld_word;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_H:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_BU:   ld_data = {24'h0, ld_shift[7:0]};
      F3_HU:   ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu_axi_lite_master.sv
// MEM-stage load/store unit: converts one load or store into a single
// AXI4-Lite transaction and holds the pipeline (mem_read_write) until done.
//   clk, rst            : clock, asynchronous active-high reset
//   mem_read/mem_write  : MEM-stage request, held stable while stalled
//   funct3, addr, wdata : access size/sign, byte address, LSB-aligned store data
//   mem_read_write      : stall to hazard unit
//   rdata               : extended load result, valid in DONE
//   misaligned, bus_err : one-cycle pulses in DONE
//   aw*/w*/b*/ar*/r*    : AXI4-Lite master channels
module lsu_axi_lite_master
  import lsu_axi_lite_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic                  mem_read_write,
  output logic [31:0]           rdata,
  output logic                  misaligned,
  output logic                  bus_err,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  output logic [2:0]            awprot,
  input  logic                  awready,
  output logic [31:0]           wdata_o,
  output logic [3:0]            wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  input  logic [1:0]            bresp,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  output logic [2:0]            arprot,
  input  logic                  arready,
  input  logic                  rvalid,
  input  logic [31:0]           rdata_i,
  input  logic [1:0]            rresp,
  output logic                  rready
);

  state_t      state, state_nxt;
  req_t        req_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        mis_q, err_q;
  logic        aw_done, w_done;

  logic        req, mis_req;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata, ld_data;

  assign req     = mem_read | mem_write;
  assign mis_req = is_misaligned(funct3, addr[1:0]);

  // Store lanes come from the live request (latched on accept); load
  // extraction uses the latched request against the incoming read data.
  lsu_data_align u_align (
    .st_funct3 (funct3),
    .st_off    (addr[1:0]),
    .st_data   (wdata),
    .st_strb   (st_strb),
    .st_wdata  (st_wdata),
    .ld_funct3 (req_q.funct3),
    .ld_off    (req_q.addr[1:0]),
    .ld_word   (rdata_i),
    .ld_data   (ld_data)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (req) state_nxt = mis_req ? ST_DONE : (mem_read ? ST_RD_ADDR : ST_WR);
      ST_RD_ADDR: if (arready) state_nxt = ST_RD_DATA;
      ST_RD_DATA: if (rvalid) state_nxt = ST_DONE;
      // awvalid is low once aw_done is set, so awready only matters before that
      ST_WR:      if ((aw_done | awready) & (w_done | wready)) state_nxt = ST_WR_RESP;
      ST_WR_RESP: if (bvalid) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs; the stall is combinational in IDLE so the request
  // cycle itself already holds the pipeline.
  always_comb begin
    arvalid        = 1'b0;
    rready         = 1'b0;
    awvalid        = 1'b0;
    wvalid         = 1'b0;
    bready         = 1'b0;
    mem_read_write = 1'b0;
    case (state)
      ST_IDLE:    mem_read_write = req;
      ST_RD_ADDR: begin arvalid = 1'b1; mem_read_write = 1'b1; end
      ST_RD_DATA: begin rready  = 1'b1; mem_read_write = 1'b1; end
      ST_WR: begin
        awvalid        = ~aw_done;
        wvalid         = ~w_done;
        mem_read_write = 1'b1;
      end
      ST_WR_RESP: begin bready = 1'b1; mem_read_write = 1'b1; end
      default: ;
    endcase
  end

  // Datapath: request latch, write-channel completion flags, result pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        ST_IDLE: if (req) begin
          if (mis_req) begin
            mis_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            req_q.addr   <= addr;
            req_q.funct3 <= funct3;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            if (mem_write) begin
              wstrb_q <= st_strb;
              wdata_q <= st_wdata;
            end
          end
        end
        ST_RD_DATA: if (rvalid) begin
          rdata_q <= (rresp == RESP_OKAY) ? ld_data : 32'h0;
          err_q   <= rresp != RESP_OKAY;
        end
        ST_WR: begin
          if (awvalid && awready) aw_done <= 1'b1;
          if (wvalid && wready)   w_done  <= 1'b1;
        end
        ST_WR_RESP: if (bvalid) err_q <= bresp != RESP_OKAY;
        default: ;
      endcase
    end
  end

  assign awaddr     = req_q.addr[ADDR_WIDTH-1:0];
  assign araddr     = req_q.addr[ADDR_WIDTH-1:0];
  assign wstrb      = wstrb_q;
  assign wdata_o    = wdata_q;
  assign rdata      = rdata_q;
  assign misaligned = mis_q;
  assign bus_err    = err_q;
  assign awprot     = 3'b000;
  assign arprot     = 3'b000;

endmodule

// File: tb/tb_lsu_axi_lite_master.sv
// Scoreboard bench for lsu_axi_lite_master: a driver issues loads/stores and
// pushes the expected outcome, a programmable-wait AXI slave answers, and a
// monitor pops and compares whenever the DUT reaches its completion cycle.
module tb_lsu_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        mem_read_write, misaligned, bus_err;
  logic [31:0] rdata;
  logic [31:0] awaddr, araddr, wdata_o;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [2:0]  awprot, arprot;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b0, rresp = 2'b0;
  logic [31:0] rdata_i = 32'h0;

  always #5 clk = ~clk;

  lsu_axi_lite_master #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .mem_read_write(mem_read_write), .rdata(rdata),
    .misaligned(misaligned), .bus_err(bus_err),
    .awaddr(awaddr), .awvalid(awvalid), .awprot(awprot), .awready(awready),
    .wdata_o(wdata_o), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arprot(arprot), .arready(arready),
    .rvalid(rvalid), .rdata_i(rdata_i), .rresp(rresp), .rready(rready)
  );

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    bit          is_load;
    bit          mis;
    bit          err;
    logic [31:0] rdata;
    int          stall;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wd;
  } exp_t;

  exp_t sb[$];

  // Slave configuration for the transaction currently open
  int          cfg_ar_w = 0, cfg_r_w = 0, cfg_aw_w = 0, cfg_w_w = 0, cfg_b_w = 0;
  logic [31:0] cfg_word = 32'h0;
  logic [1:0]  cfg_rresp = 2'b0, cfg_bresp = 2'b0;

  // Slave state
  int          arc = 0, rc = 0, awc = 0, wc = 0, bc = 0;
  bit          rd_pend = 0, aw_got = 0, w_got = 0;
  int          ar_n = 0, aw_n = 0;
  logic [31:0] cap_araddr = 0, cap_awaddr = 0, cap_wdata = 0;
  logic [3:0]  cap_wstrb = 0;
  bit          p_ok = 0, p_arvalid = 0, p_arready = 0, p_awvalid = 0, p_awready = 0;
  bit          p_wvalid = 0, p_wready = 0;
  logic [31:0] p_araddr = 0, p_awaddr = 0, p_wdata = 0;
  logic [3:0]  p_wstrb = 0;

  // AXI slave; decisions at negedge, handshakes land on the next posedge.
  // Also checks that a pending valid and its payload are held.
  always @(negedge clk) begin
    if (rst) begin
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
      arc = 0; rc = 0; awc = 0; wc = 0; bc = 0;
      rd_pend = 0; aw_got = 0; w_got = 0; p_ok = 0;
    end else begin
      if (p_ok) begin
        if (p_arvalid && !p_arready) begin
          check("arvalid_hold", 32'(arvalid), 32'd1);
          check("araddr_stable", araddr, p_araddr);
        end
        if (p_awvalid && !p_awready) begin
          check("awvalid_hold", 32'(awvalid), 32'd1);
          check("awaddr_stable", awaddr, p_awaddr);
        end
        if (p_wvalid && !p_wready) begin
          check("wvalid_hold", 32'(wvalid), 32'd1);
          check("wstrb_stable", 32'(wstrb), 32'(p_wstrb));
          check("wdata_stable", wdata_o, p_wdata);
        end
      end
      if (arready) arready = 0;
      else if (arvalid) begin
        if (arc < cfg_ar_w) arc++;
        else begin arready = 1; arc = 0; ar_n++; cap_araddr = araddr; rd_pend = 1; end
      end
      if (rvalid) rvalid = 0;
      else if (rd_pend && rready) begin
        if (rc < cfg_r_w) rc++;
        else begin rvalid = 1; rdata_i = cfg_word; rresp = cfg_rresp; rd_pend = 0; rc = 0; end
      end
      if (awready) awready = 0;
      else if (awvalid) begin
        if (awc < cfg_aw_w) awc++;
        else begin awready = 1; awc = 0; aw_n++; cap_awaddr = awaddr; aw_got = 1; end
      end
      if (wready) wready = 0;
      else if (wvalid) begin
        if (wc < cfg_w_w) wc++;
        else begin wready = 1; wc = 0; cap_wdata = wdata_o; cap_wstrb = wstrb; w_got = 1; end
      end
      if (bvalid) bvalid = 0;
      else if (aw_got && w_got && bready) begin
        if (bc < cfg_b_w) bc++;
        else begin bvalid = 1; bresp = cfg_bresp; aw_got = 0; w_got = 0; bc = 0; end
      end
      p_ok = 1;
      p_arvalid = arvalid; p_arready = arready; p_araddr = araddr;
      p_awvalid = awvalid; p_awready = awready; p_awaddr = awaddr;
      p_wvalid = wvalid;   p_wready = wready;   p_wdata = wdata_o; p_wstrb = wstrb;
    end
  end

  // Monitor: the completion cycle is the one where a request is present but
  // the stall is low.
  int   stall_cnt = 0, base_ar = 0, base_aw = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      stall_cnt = 0; base_ar = ar_n; base_aw = aw_n;
    end else begin
      if (mem_read_write) stall_cnt++;
      if ((mem_read || mem_write) && !mem_read_write) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done got=1 exp=0 t=%0t", $time);
        end else begin
          mon_e = sb.pop_front();
          check("stall_cycles", 32'(stall_cnt), 32'(mon_e.stall));
          check("misaligned", 32'(misaligned), 32'(mon_e.mis));
          check("bus_err", 32'(bus_err), 32'(mon_e.err));
          if (mon_e.mis) begin
            check("mis_rdata", rdata, 32'h0);
            check("mis_bus_activity", 32'((ar_n - base_ar) + (aw_n - base_aw)), 32'd0);
          end else if (mon_e.is_load) begin
            check("load_rdata", rdata, mon_e.rdata);
            check("araddr", cap_araddr, mon_e.addr);
            check("ar_handshakes", 32'(ar_n - base_ar), 32'd1);
          end else begin
            check("awaddr", cap_awaddr, mon_e.addr);
            check("wstrb", 32'(cap_wstrb), 32'(mon_e.strb));
            check("wdata_o", cap_wdata, mon_e.wd);
            check("aw_handshakes", 32'(aw_n - base_aw), 32'd1);
          end
        end
        stall_cnt = 0; base_ar = ar_n; base_aw = aw_n;
      end else begin
        check("misaligned_quiet", 32'(misaligned), 32'd0);
        check("bus_err_quiet", 32'(bus_err), 32'd0);
      end
    end
  end

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Issue one request (called at posedge+1), wait for its completion cycle,
  // then release the request at the following posedge+1.
  // Waits: load (wa=AR, wb=R); store (wa=AW, wb=W, wc=B).
  task automatic issue(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] word, input logic [1:0] resp,
                       input int wa, input int wb, input int wc);
    exp_t e;
    int   v, n, off, sz;
    off = int'(a[1:0]);
    sz  = int'(f3[1:0]);
    e.is_load = ld; e.addr = a; e.strb = 4'h0; e.wd = 32'h0; e.rdata = 32'h0; e.err = 0;
    e.mis = (sz == 1 && (off % 2) == 1) || (sz == 2 && off != 0);
    if (e.mis) e.stall = 1;
    else if (ld) begin
      e.stall = 3 + wa + wb;
      e.err   = resp != 2'b00;
      if (!e.err) begin
        if (sz == 0) begin
          v = int'((word >> (8 * off)) & 32'hFF);
          if (!f3[2] && v >= 128) v -= 256;
          e.rdata = 32'(v);
        end else if (sz == 1) begin
          v = int'((word >> (8 * off)) & 32'hFFFF);
          if (!f3[2] && v >= 32768) v -= 65536;
          e.rdata = 32'(v);
        end else e.rdata = word;
      end
    end else begin
      e.stall = 3 + ((wa > wb) ? wa : wb) + wc;
      e.err   = resp != 2'b00;
      if (sz == 0) begin e.strb = 4'(1 << off); e.wd = (wd & 32'hFF) * 32'h0101_0101; end
      else if (sz == 1) begin e.strb = 4'(3 << off); e.wd = (wd & 32'hFFFF) * 32'h0001_0001; end
      else begin e.strb = 4'hF; e.wd = wd; end
    end
    cfg_ar_w = wa; cfg_r_w = wb; cfg_aw_w = wa; cfg_w_w = wb; cfg_b_w = wc;
    cfg_word = word; cfg_rresp = resp; cfg_bresp = resp;
    sb.push_back(e);
    mem_read = ld; mem_write = !ld; funct3 = f3; addr = a; wdata = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (mem_read_write && n < 200);
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL completion_timeout got=%0d exp<200 t=%0t", n, $time);
      finish_run();
    end
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0;
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, lf3;
    bit          ld;
    int          n;
    lf3 = {8'h0, 3'b101, 3'b100, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(mem_read_write), 32'd0);
    check("rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_pulses", 32'({misaligned, bus_err}), 32'd0);
    check("rst_araddr", araddr, 32'h0);
    check("rst_awaddr", awaddr, 32'h0);
    check("rst_wstrb", 32'(wstrb), 32'd0);
    check("rst_wdata_o", wdata_o, 32'h0);
    @(posedge clk); #1 rst = 0;

    // Directed cases
    issue(1, 3'b010, 32'h100, 0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0);        // LW
    issue(1, 3'b000, 32'h103, 0, 32'h80FF_0000, 2'b00, 0, 0, 0);        // LB
    issue(1, 3'b100, 32'h103, 0, 32'h80FF_0000, 2'b00, 0, 0, 0);        // LBU
    issue(0, 3'b001, 32'h202, 32'h1234, 0, 2'b00, 0, 2, 0);             // SH, wready late
    issue(0, 3'b001, 32'h201, 32'h1234, 0, 2'b00, 0, 0, 0);             // SH misaligned
    issue(1, 3'b010, 32'h101, 0, 32'h1111_1111, 2'b00, 0, 0, 0);        // LW misaligned
    issue(0, 3'b010, 32'h300, 32'hCAFE_F00D, 0, 2'b10, 0, 0, 0);        // SW SLVERR
    issue(1, 3'b010, 32'h304, 0, 32'h0BAD_F00D, 2'b00, 4, 0, 0);        // LW, 4 AR waits
    issue(1, 3'b001, 32'h002, 0, 32'h8001_7FFF, 2'b11, 1, 2, 0);        // LH DECERR
    issue(0, 3'b000, 32'h007, 32'h0000_00A5, 0, 2'b00, 3, 0, 2);        // SB, awready late

    // Reset while in RD_DATA
    cfg_ar_w = 0; cfg_r_w = 6; cfg_word = 32'h5555_AAAA; cfg_rresp = 2'b00;
    mem_read = 1; funct3 = 3'b010; addr = 32'h40;
    n = 0;
    do begin @(negedge clk); n++; end while (!rready && n < 20);
    check("reach_rd_data", 32'(rready), 32'd1);
    #1; rst = 1; mem_read = 0;
    #1;
    check("midrst_arvalid", 32'(arvalid), 32'd0);
    check("midrst_rready", 32'(rready), 32'd0);
    check("midrst_idle", 32'(mem_read_write), 32'd0);
    check("midrst_rdata", rdata, 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 0;
    issue(1, 3'b010, 32'h48, 0, 32'h1357_9BDF, 2'b00, 0, 1, 0);

    // Randomized traffic, back-to-back or with short gaps
    for (int i = 0; i < 250; i++) begin
      ld = $urandom_range(0, 1) == 1;
      if (ld) f3 = 3'(lf3 >> (3 * $urandom_range(0, 4)));
      else    f3 = 3'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      issue(ld, f3, a, $urandom, $urandom,
            ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    finish_run();
  end

endmodule
